lzc_norm_arbiter: RTL

- Shares one leading-zero counting unit among N_REQ requesters, each sending an operand to be normalized.
- Round-robin arbitration picks one requester per cycle; the winner's operand passes through a 2-stage pipeline (capture, then count+shift).
- The output is the left-normalized operand, its leading-zero count and the requester ID, under a valid/ready handshake with full backpressure.
- Sits in front of the ROSETTA normalization path: mantissa producers request here instead of each instantiating its own counter.

---
 rtl/lzc_pkg.sv | 25 ++
 rtl/lzcu_core.sv | 41 ++++
 rtl/lzc_norm_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// Shared constants and elaboration-time helpers for the shared leading-zero
// normalizer and its round-robin front end.
package lzc_pkg;

    localparam int LZC_WIDTH_DEF = 7;

    // Operand width implied by a count width: the count must reach I_WIDTH itself.
    function automatic int i_width(input int lzc_w);
        return 1 << (lzc_w - 1);
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/lzcu_core.sv
// Recursive combinational leading-zero counter; out == I_WIDTH for a zero operand.
module lzcu_core #(
    parameter int I_WIDTH   = 64,
    parameter int LZC_WIDTH = 7
) (
    input  logic [I_WIDTH-1:0]   in,
    output logic [LZC_WIDTH-1:0] out
);

    generate
        if (I_WIDTH == 2) begin : g_leaf
            always_comb begin
                out = {~in[1] & ~in[0], ~in[1] & in[0]};
            end
        end else begin : g_split
            localparam int HW = I_WIDTH / 2;
            logic [LZC_WIDTH-2:0] hi_cnt;
            logic [LZC_WIDTH-2:0] lo_cnt;

            lzcu_core #(.I_WIDTH(HW), .LZC_WIDTH(LZC_WIDTH-1)) u_hi (
                .in  (in[I_WIDTH-1:HW]),
                .out (hi_cnt)
            );
            lzcu_core #(.I_WIDTH(HW), .LZC_WIDTH(LZC_WIDTH-1)) u_lo (
                .in  (in[HW-1:0]),
                .out (lo_cnt)
            );

            // A set MSB in a half's count means that half was all zero.
            always_comb begin
                if (!hi_cnt[LZC_WIDTH-2])
                    out = {1'b0, hi_cnt};
                else if (lo_cnt[LZC_WIDTH-2])
                    out = {1'b1, {(LZC_WIDTH-1){1'b0}}};
                else
                    out = {2'b01, lo_cnt[LZC_WIDTH-3:0]};
            end
        end
    endgenerate

endmodule

// File: rtl/lzc_norm_arbiter.sv
// Round-robin front end sharing one leading-zero counter among N_REQ requesters;
// two-stage pipeline (capture, count+shift) with valid/ready backpressure.
module lzc_norm_arbiter
    import lzc_pkg::*;
#(
    parameter int LZC_WIDTH = LZC_WIDTH_DEF,
    parameter int I_WIDTH   = i_width(LZC_WIDTH),
    parameter int N_REQ     = 4,
    parameter int ID_W      = clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*I_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [I_WIDTH-1:0]       out_data,
    output logic [LZC_WIDTH-1:0]     out_cnt,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_zero
);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [I_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [ID_W-1:0]      s1_id_q, s1_id_d;
    logic                 out_valid_q, out_valid_d;
    logic [I_WIDTH-1:0]   out_data_q, out_data_d;
    logic [LZC_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic                 out_zero_q, out_zero_d;

    logic                 adv1, adv2, accept, found;
    logic [ID_W-1:0]      winner, scan_idx;
    logic [I_WIDTH-1:0]   win_data;
    logic [LZC_WIDTH-1:0] cnt;

    assign adv2   = !out_valid_q || out_ready;
    assign adv1   = !s1_valid_q || adv2;
    assign accept = adv1 && found;

    // Scan from the pointer, wrapping, and keep the first valid requester.
    always_comb begin
        found    = 1'b0;
        winner   = ptr_q;
        scan_idx = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == winner) win_data = req_data[k*I_WIDTH +: I_WIDTH];
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && found && adv1) req_ready[winner] = 1'b1;
    end

    lzcu_core #(.I_WIDTH(I_WIDTH), .LZC_WIDTH(LZC_WIDTH)) u_lzc (
        .in  (s1_data_q),
        .out (cnt)
    );

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_id_d     = s1_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_id_d    = out_id_q;
        out_zero_d  = out_zero_q;

        if (accept) begin
            ptr_d      = ID_W'(rr_next(int'(winner), N_REQ));
            s1_valid_d = 1'b1;
            s1_data_d  = win_data;
            s1_id_d    = winner;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end

        // A shift by the full width naturally yields zero for the all-zero case.
        if (adv2) begin
            out_valid_d = s1_valid_q;
            out_data_d  = s1_data_q << cnt;
            out_cnt_d   = cnt;
            out_id_d    = s1_id_q;
            out_zero_d  = (cnt == LZC_WIDTH'(I_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_id_q    <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_id_q    <= out_id_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_id    = out_id_q;
    assign out_zero  = out_zero_q;

endmodule
